sprite_plot_scheduler: RTL and testbench

//  Time-multiplexes one VGA adapter plot port among N sprite engines (cars, player).

---
 rtl/sprite_plot_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_plot_scheduler
// Purpose  : Once per frame tick, grants the VGA plot port to each enabled
//            sprite engine in index order. Optional per-engine watchdog is
//            built when SPRITE_SCHED_WATCHDOG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module sprite_plot_scheduler #(
  parameter int N_SPRITES   = 8,
  parameter int FRAME_TICKS = 833333,
  parameter int TIMEOUT     = 65535
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_SPRITES-1:0]   enable_mask,
  input  logic [8*N_SPRITES-1:0] req_x,
  input  logic [7*N_SPRITES-1:0] req_y,
  input  logic [3*N_SPRITES-1:0] req_colour,
  input  logic [N_SPRITES-1:0]   req_plot,
  input  logic [N_SPRITES-1:0]   done,
  output logic [N_SPRITES-1:0]   en,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   pass_done,
  output logic                   overrun,
  output logic [N_SPRITES-1:0]   timeout_err
);

  localparam int IW = $clog2(N_SPRITES + 1);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SPRITES);
  localparam logic [TW-1:0] TICK_MAX = TW'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [N_SPRITES-1:0] mask, mask_nxt;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 route;

  logic [N_SPRITES-1:0] grant;
  logic                 sel_mask, sel_done, sel_plot;
  logic [7:0]           sel_x;
  logic [6:0]           sel_y;
  logic [2:0]           sel_colour;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // idx may equal N_SPRITES (end of scan); no engine matches then.
  always_comb begin
    grant      = '0;
    sel_mask   = 1'b0;
    sel_done   = 1'b0;
    sel_plot   = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx == IW'(i)) begin
        grant[i]   = 1'b1;
        sel_mask   = mask[i];
        sel_done   = done[i];
        sel_plot   = req_plot[i];
        sel_x      = req_x[8*i +: 8];
        sel_y      = req_y[7*i +: 7];
        sel_colour = req_colour[3*i +: 3];
      end
    end
  end

`ifdef SPRITE_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  logic [WW-1:0]        wd_cnt, wd_cnt_nxt, wd_inc;
  logic [N_SPRITES-1:0] to_flags, to_flags_nxt;

  assign wd_inc      = wd_cnt + 1'b1;
  assign timeout_err = to_flags;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt   <= '0;
      to_flags <= '0;
    end else begin
      wd_cnt   <= wd_cnt_nxt;
      to_flags <= to_flags_nxt;
    end
  end
`else
  assign timeout_err = '0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask;
    en        = '0;
    pass_done = 1'b0;
`ifdef SPRITE_SCHED_WATCHDOG_EN
    wd_cnt_nxt   = wd_cnt;
    to_flags_nxt = to_flags;
`endif
    case (state)
      S_IDLE: begin
        if (tick) begin
          mask_nxt  = enable_mask;
          idx_nxt   = '0;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx == LAST_IDX)  state_nxt = S_END;
        else if (sel_mask)    state_nxt = S_ISSUE;
        else                  idx_nxt   = idx + 1'b1;
      end
      S_ISSUE: begin
        en        = grant;
        state_nxt = S_BUSY;
`ifdef SPRITE_SCHED_WATCHDOG_EN
        wd_cnt_nxt = '0;
`endif
      end
      S_BUSY: begin
        // A finish arriving on the final watchdog cycle still counts as a finish.
        if (sel_done) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_SCAN;
        end
`ifdef SPRITE_SCHED_WATCHDOG_EN
        else if (wd_inc == WD_LIMIT) begin
          to_flags_nxt = to_flags | grant;
          idx_nxt      = idx + 1'b1;
          state_nxt    = S_SCAN;
        end else begin
          wd_cnt_nxt = wd_inc;
        end
`endif
      end
      S_END: begin
        pass_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign route      = (state == S_ISSUE) || (state == S_BUSY);
  assign vga_x      = route ? sel_x      : '0;
  assign vga_y      = route ? sel_y      : '0;
  assign vga_colour = route ? sel_colour : '0;
  assign vga_plot   = route ? sel_plot   : 1'b0;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      idx     <= '0;
      mask    <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      mask  <= mask_nxt;
      if (tick && (state != S_IDLE)) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_plot_scheduler
// Purpose  : Randomized scoreboard bench; each pass's timeline is computed up
//            front from the mask and engine finish delays.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_plot_scheduler;

  localparam int N  = 4;
  localparam int FT = 100;
  localparam int TO = 50;
`ifdef SPRITE_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   enable_mask = '0;
  logic [8*N-1:0] req_x = '0;
  logic [7*N-1:0] req_y = '0;
  logic [3*N-1:0] req_colour = '0;
  logic [N-1:0]   req_plot = '0;
  logic [N-1:0]   done = '0;
  logic [N-1:0]   en;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           pass_done;
  logic           overrun;
  logic [N-1:0]   timeout_err;

  always #5 clk = ~clk;

  sprite_plot_scheduler #(.N_SPRITES(N), .FRAME_TICKS(FT), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .enable_mask(enable_mask),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_plot(req_plot),
    .done(done), .en(en), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .pass_done(pass_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rn    = 1'b0;

  // Reference timeline: which engine owns the port each cycle, and event times.
  int           c0 = 0;
  bit           in_reset = 1'b1;
  int           pass_end = -1;
  int           force_mask = -1;
  int           dly_cfg [N];
  int           own_at [int];
  bit           iss_at [int];
  bit           busy_at [int];
  logic [N-1:0] done_ev [int];
  logic [N-1:0] to_ev [int];
  bit           ovr_ev [int];
  bit           clr_ev [int];
  int           en_cyc_q [$];
  int           en_idx_q [$];
  int           pd_q [$];
  logic [N-1:0] exp_to = '0;
  bit           exp_ovr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic start_pass(input int tk, input logic [N-1:0] m);
    int t, d, eff, l;
    logic [N-1:0] b;
    t = tk + 1;
    for (int i = 0; i < N; i++) begin
      b = '0;
      b[i] = 1'b1;
      busy_at[t] = 1'b1;
      if (!m[i]) begin
        t++;
      end else begin
        d   = (dly_cfg[i] >= 0) ? dly_cfg[i] : int'($urandom_range(1, 20));
        eff = (WD && d > TO) ? TO : d;
        en_cyc_q.push_back(t + 1);
        en_idx_q.push_back(i);
        iss_at[t + 1] = 1'b1;
        for (int k = t + 1; k <= t + 1 + eff; k++) begin
          own_at[k]  = i;
          busy_at[k] = 1'b1;
        end
        if (WD && d > TO) begin
          if (!to_ev.exists(t + 2 + TO)) to_ev[t + 2 + TO] = '0;
          to_ev[t + 2 + TO] |= b;
        end else begin
          l = $urandom_range(1, 3);
          for (int k = 0; k < l; k++) begin
            if (!done_ev.exists(t + 1 + d + k)) done_ev[t + 1 + d + k] = '0;
            done_ev[t + 1 + d + k] |= b;
          end
        end
        t = t + 2 + eff;
      end
    end
    busy_at[t]     = 1'b1;
    busy_at[t + 1] = 1'b1;
    pd_q.push_back(t + 1);
    pass_end = t + 1;
  endtask

  task automatic purge(input int c);
    for (int k = c + 1; k <= pass_end + 2; k++) begin
      if (own_at.exists(k))  own_at.delete(k);
      if (iss_at.exists(k))  iss_at.delete(k);
      if (busy_at.exists(k)) busy_at.delete(k);
      if (to_ev.exists(k))   to_ev.delete(k);
      if (ovr_ev.exists(k))  ovr_ev.delete(k);
    end
    while (en_cyc_q.size() > 0 && en_cyc_q[$] > c) begin
      void'(en_cyc_q.pop_back());
      void'(en_idx_q.pop_back());
    end
    while (pd_q.size() > 0 && pd_q[$] > c) void'(pd_q.pop_back());
    pass_end = -1;
  endtask

  task automatic step();
    logic [N-1:0] nz;
    @(posedge clk);
    cyc++;
    #1;
    resetn      = rn;
    enable_mask = (force_mask >= 0) ? N'(force_mask) : N'($urandom);
    req_x       = (8*N)'($urandom);
    req_y       = (7*N)'($urandom);
    req_colour  = (3*N)'($urandom);
    req_plot    = N'($urandom);
    if (!rn) begin
      purge(cyc);
      in_reset = 1'b1;
      clr_ev[cyc + 1] = 1'b1;
    end else begin
      if (in_reset) begin
        in_reset = 1'b0;
        c0 = cyc;
      end
      if ((cyc - c0) % FT == FT - 1) begin
        if (cyc <= pass_end) ovr_ev[cyc + 1] = 1'b1;
        else start_pass(cyc, enable_mask);
      end
    end
    // Spurious finishes from engines that do not currently hold the port.
    nz = '0;
    for (int j = 0; j < N; j++)
      if ($urandom_range(0, 7) == 0 &&
          !(own_at.exists(cyc) && own_at[cyc] == j && !iss_at.exists(cyc)))
        nz[j] = 1'b1;
    done = (done_ev.exists(cyc) ? done_ev[cyc] : '0) | nz;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly_cfg[0] = a; dly_cfg[1] = b; dly_cfg[2] = c; dly_cfg[3] = d;
  endtask

  int           m_own, m_ec, m_ei;
  logic [18:0]  m_vga;

  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (clr_ev.exists(cyc)) begin
        exp_to  = '0;
        exp_ovr = 1'b0;
      end
      if (to_ev.exists(cyc))  exp_to |= to_ev[cyc];
      if (ovr_ev.exists(cyc)) exp_ovr = 1'b1;
      m_own = own_at.exists(cyc) ? own_at[cyc] : -1;
      if (m_own >= 0)
        m_vga = {req_x[8*m_own +: 8], req_y[7*m_own +: 7], req_colour[3*m_own +: 3], req_plot[m_own]};
      else
        m_vga = '0;
      chk("vga", {vga_x, vga_y, vga_colour, vga_plot}, m_vga);
      chk("busy", busy, busy_at.exists(cyc));
      chk("timeout_err", timeout_err, exp_to);
      chk("overrun", overrun, exp_ovr);
      if (en !== '0) begin
        if (en_cyc_q.size() == 0) chk("en_unexpected", en, 0);
        else begin
          m_ec = en_cyc_q.pop_front();
          m_ei = en_idx_q.pop_front();
          chk("en_cycle", cyc, m_ec);
          chk("en_onehot", en, 64'(1) << m_ei);
        end
      end else if (en_cyc_q.size() > 0 && en_cyc_q[0] <= cyc) begin
        void'(en_cyc_q.pop_front());
        m_ei = en_idx_q.pop_front();
        chk("en_missing", en, 64'(1) << m_ei);
      end
      if (pass_done !== 1'b0) begin
        if (pd_q.size() == 0) chk("pass_done_unexpected", pass_done, 0);
        else chk("pass_done_cycle", cyc, pd_q.pop_front());
      end else if (pd_q.size() > 0 && pd_q[0] <= cyc) begin
        void'(pd_q.pop_front());
        chk("pass_done_missing", pass_done, 1);
      end
    end
  end

  initial begin
    int guard;
    set_dly(-1, -1, -1, -1);
    rn = 1'b0;
    run(3);
    rn = 1'b1;

    force_mask = 4'hF; set_dly(10, 10, 10, 10);   run(100);
    force_mask = 4'h5;                            run(100);
    force_mask = -1;   set_dly(-1, -1, -1, -1);   run(600);
    force_mask = 0;                               run(100);

    force_mask = 4'hF; set_dly(5, 150, 5, 5);     run(100);
    force_mask = -1;   set_dly(-1, -1, -1, -1);   run(300);

    force_mask = 4'hF; set_dly(5, 5, 200, 5);     run(100);
    force_mask = -1;   set_dly(-1, -1, -1, -1);   run(300);

    // Abort a pass while engine 1 holds the port.
    force_mask = 4'hF; set_dly(30, 30, 30, 30);   run(100);
    guard = 0;
    while (!(own_at.exists(cyc) && own_at[cyc] == 1 && !iss_at.exists(cyc)) && guard < 200) begin
      step();
      guard++;
    end
    chk("wait_engine1_busy", guard < 200, 1);
    rn = 1'b0; step();
    rn = 1'b1;
    force_mask = -1;   set_dly(-1, -1, -1, -1);   run(200);
    force_mask = 0;                               run(100);
    run(20);

    @(negedge clk);
    #1;
    chk("en_queue_drained", en_cyc_q.size(), 0);
    chk("pass_done_queue_drained", pd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
